// File: rtl/pc_gen.sv
// pc_gen: RV32I program-counter generator with fetch handshake, redirect, trap and halt/resume.
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   stall_i                        hold PC and withdraw the fetch request
//   redirect_valid_i/target_i      taken branch/jump and its target
//   trap_i                         jump to TRAP_VECTOR
//   halt_req_i, resume_i           enter / leave HALT
//   fetch_ready_i                  imem accepts fetch_addr_o this cycle
//   fetch_valid_o, fetch_addr_o    fetch request and current PC
//   pc_plus4_o                     fetch_addr_o + 4
//   misaligned_exc_o, bad_addr_o   misaligned-redirect pulse and offending target
//   halted_o                       high while in HALT
//   fetch_count_o                  accepted fetch counter
module pc_gen #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [XLEN-1:0]  redirect_target_i,
  input  logic             trap_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  input  logic             fetch_ready_i,
  output logic             fetch_valid_o,
  output logic [XLEN-1:0]  fetch_addr_o,
  output logic [XLEN-1:0]  pc_plus4_o,
  output logic             misaligned_exc_o,
  output logic [XLEN-1:0]  bad_addr_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] fetch_count_o
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, bad_q, bad_d;
  logic [CNT_W-1:0] cnt_q;
  logic exc_q, exc_d, run, mis, fire;
  assign run = state_q == RUN;
  // Trap outranks a misaligned redirect, so no exception is flagged when both arrive.
  assign mis = run && !trap_i && redirect_valid_i && redirect_target_i[1:0] != 2'b00;
  assign fetch_valid_o = run && !stall_i;
  assign fire = fetch_valid_o && fetch_ready_i;
  assign pc_plus4_o = pc_q + XLEN'(4);
  assign fetch_addr_o = pc_q;
  assign misaligned_exc_o = exc_q;
  assign bad_addr_o = bad_q;
  assign halted_o = state_q == HALT;
  assign fetch_count_o = cnt_q;
  always_comb begin
    pc_d = pc_q;
    if (run)
      pc_d = (trap_i || mis) ? TRAP_VECTOR :
             redirect_valid_i ? redirect_target_i :
             fire ? pc_plus4_o : pc_q;
    exc_d = mis;
    bad_d = mis ? redirect_target_i : bad_q;
    state_d = state_q == BOOT ? RUN :
              run ? (halt_req_i ? HALT : RUN) :
              (resume_i && !halt_req_i) ? RUN : HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q <= RESET_VECTOR;
      exc_q <= 1'b0;
      bad_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      exc_q <= exc_d;
      bad_q <= bad_d;
      cnt_q <= cnt_q + CNT_W'(fire);
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen.
module tb_pc_gen;
  logic clk = 1'b0, reset = 1'b1;
  logic stall = 1'b0, redirect_valid = 1'b0, trap = 1'b0, halt_req = 1'b0, resume = 1'b0, fetch_ready = 1'b1;
  logic [31:0] redirect_target = '0;
  logic fetch_valid, misaligned_exc, halted;
  logic [31:0] fetch_addr, pc_plus4, bad_addr, fetch_count;
  int tests = 0, fails = 0;
  pc_gen dut (
    .clk(clk), .reset(reset), .stall_i(stall), .redirect_valid_i(redirect_valid),
    .redirect_target_i(redirect_target), .trap_i(trap), .halt_req_i(halt_req),
    .resume_i(resume), .fetch_ready_i(fetch_ready), .fetch_valid_o(fetch_valid),
    .fetch_addr_o(fetch_addr), .pc_plus4_o(pc_plus4), .misaligned_exc_o(misaligned_exc),
    .bad_addr_o(bad_addr), .halted_o(halted), .fetch_count_o(fetch_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [31:0] addr, input logic v,
                         input logic h, input logic [31:0] cnt);
    chk({tag, " addr"}, fetch_addr, addr);
    chk({tag, " valid"}, 32'(fetch_valid), 32'(v));
    chk({tag, " halted"}, 32'(halted), 32'(h));
    chk({tag, " count"}, fetch_count, cnt);
  endtask
  initial begin
    step(); step();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 32'd0);
    chk("reset bad_addr", bad_addr, 32'h0);
    chk("reset exc", 32'(misaligned_exc), 32'h0);
    reset = 1'b0;
    #1 chk("boot valid", 32'(fetch_valid), 32'h0);
    step(); chk_all("t1 run0", 32'h0, 1'b1, 1'b0, 32'd0);
    chk("t1 plus4", pc_plus4, 32'h4);
    step(); chk_all("t1 run4", 32'h4, 1'b1, 1'b0, 32'd1);
    step(); chk_all("t1 run8", 32'h8, 1'b1, 1'b0, 32'd2);
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("t2 wait", 32'h8, 1'b1, 1'b0, 32'd2);
    end
    fetch_ready = 1'b1;
    step(); chk_all("t2 resume", 32'hC, 1'b1, 1'b0, 32'd3);
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    #1 chk("t3 stall valid", 32'(fetch_valid), 32'h0);
    step(); chk_all("t3 redir", 32'h40, 1'b0, 1'b0, 32'd3);
    redirect_valid = 1'b0;
    step(); chk_all("t3 stalled", 32'h40, 1'b0, 1'b0, 32'd3);
    stall = 1'b0;
    step(); chk_all("t3 go", 32'h44, 1'b1, 1'b0, 32'd4);
    redirect_valid = 1'b1; redirect_target = 32'h42;
    step(); chk_all("t4 mis", 32'h100, 1'b1, 1'b0, 32'd5);
    chk("t4 exc", 32'(misaligned_exc), 32'h1);
    chk("t4 bad", bad_addr, 32'h42);
    redirect_valid = 1'b0;
    step(); chk_all("t4 after", 32'h104, 1'b1, 1'b0, 32'd6);
    chk("t4 exc drop", 32'(misaligned_exc), 32'h0);
    chk("t4 bad held", bad_addr, 32'h42);
    trap = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80; halt_req = 1'b1;
    step(); chk_all("t5 trap halt", 32'h100, 1'b0, 1'b1, 32'd7);
    chk("t5 no exc", 32'(misaligned_exc), 32'h0);
    trap = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
    step(); chk_all("t5 halted", 32'h100, 1'b0, 1'b1, 32'd7);
    redirect_valid = 1'b1; redirect_target = 32'h200; trap = 1'b1;
    step(); chk_all("t5 halt ignores", 32'h100, 1'b0, 1'b1, 32'd7);
    redirect_valid = 1'b0; trap = 1'b0; resume = 1'b1; halt_req = 1'b1;
    step(); chk_all("t5 res+halt", 32'h100, 1'b0, 1'b1, 32'd7);
    halt_req = 1'b0;
    step(); chk_all("t5 resumed", 32'h100, 1'b1, 1'b0, 32'd7);
    resume = 1'b0;
    step(); chk_all("t5 fetch", 32'h104, 1'b1, 1'b0, 32'd8);
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step(); chk_all("t6 top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd9);
    chk("t6 plus4 wrap", pc_plus4, 32'h0);
    redirect_valid = 1'b0;
    step(); chk_all("t6 wrap", 32'h0, 1'b1, 1'b0, 32'd10);
    halt_req = 1'b1;
    step(); chk_all("t6 halt", 32'h4, 1'b0, 1'b1, 32'd11);
    halt_req = 1'b0; reset = 1'b1; stall = 1'b1;
    step(); chk_all("t6 reset", 32'h0, 1'b0, 1'b0, 32'd0);
    chk("t6 reset bad", bad_addr, 32'h0);
    reset = 1'b0; stall = 1'b0;
    step(); chk_all("t6 boot exit", 32'h0, 1'b1, 1'b0, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
